// File: rtl/rope_game_pkg.sv
// Shared widths, state/winner encodings and the pending-pull counter helper
// for the rope-game controller.
package rope_game_pkg;

  localparam int LOC_W   = 10;
  localparam int CNT_W   = 4;
  localparam int DELTA_W = 12;

  typedef logic [1:0] state_t;
  localparam state_t StIdle      = 2'd0;
  localparam state_t StCountdown = 2'd1;
  localparam state_t StPlay      = 2'd2;
  localparam state_t StWon       = 2'd3;

  typedef logic [1:0] winner_t;
  localparam winner_t WinNone  = 2'd0;
  localparam winner_t WinLeft  = 2'd1;
  localparam winner_t WinRight = 2'd2;

  // A request landing on the frame tick belongs to the next frame.
  function automatic logic [CNT_W-1:0] cnt_next(logic [CNT_W-1:0] cnt, logic req, logic tick);
    if (tick) begin
      return {{(CNT_W-1){1'b0}}, req};
    end else if (req && (cnt != {CNT_W{1'b1}})) begin
      return cnt + 1'b1;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser with a registered single-cycle edge pulse, three
// clocks after the qualifying input edge.
module sync_edge #(
  parameter bit Falling = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic s1_q, s2_q, s3_q, pulse_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      s1_q    <= din;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      pulse_q <= Falling ? (s3_q & ~s2_q) : (s2_q & ~s3_q);
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/rope_game_ctrl.sv
// Rope-game sequencer: idle/countdown/play/won FSM, per-frame net-pull
// application to the rope position, and the level win interrupt.
module rope_game_ctrl
  import rope_game_pkg::*;
#(
  parameter int CENTER           = 320,
  parameter int ROPE_MIN         = 0,
  parameter int ROPE_MAX         = 639,
  parameter int STEP             = 4,
  parameter int LEFT_WIN         = 160,
  parameter int RIGHT_WIN        = 480,
  parameter int COUNTDOWN_FRAMES = 180,
  parameter int VSYNC_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_vsync,
  input  logic       i_pull_l,
  input  logic       i_pull_r,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic       i_irq_ack,
  output logic [9:0] o_rope_loc,
  output logic [1:0] o_state,
  output logic [1:0] o_winner,
  output logic [7:0] o_count,
  output logic       o_irq
);

  logic frame_tick, req_l, req_r;

  sync_edge #(.Falling(VSYNC_ACTIVE_LOW != 0)) u_vsync (
    .clk  (clk),
    .rst  (rst),
    .din  (i_vsync),
    .pulse(frame_tick)
  );

  sync_edge #(.Falling(1'b0)) u_pull_l (
    .clk  (clk),
    .rst  (rst),
    .din  (i_pull_l),
    .pulse(req_l)
  );

  sync_edge #(.Falling(1'b0)) u_pull_r (
    .clk  (clk),
    .rst  (rst),
    .din  (i_pull_r),
    .pulse(req_r)
  );

  state_t             state_q, state_d;
  winner_t            winner_q, winner_d;
  logic [LOC_W-1:0]   loc_q, loc_d;
  logic [7:0]         count_q, count_d;
  logic [CNT_W-1:0]   cnt_l_q, cnt_l_d, cnt_r_q, cnt_r_d;
  logic               irq_q, irq_d;
  logic               win_set;
  logic signed [DELTA_W-1:0] delta;
  int                 next_i;

  // Net pull to a clamped candidate position.
  always_comb begin
    delta  = DELTA_W'((int'(cnt_r_q) - int'(cnt_l_q)) * STEP);
    next_i = int'(loc_q) + int'(delta);
    if (next_i < ROPE_MIN) next_i = ROPE_MIN;
    if (next_i > ROPE_MAX) next_i = ROPE_MAX;
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    loc_d    = loc_q;
    count_d  = count_q;
    cnt_l_d  = '0;
    cnt_r_d  = '0;
    win_set  = 1'b0;
    if (i_abort) begin
      state_d  = StIdle;
      winner_d = WinNone;
      loc_d    = LOC_W'(CENTER);
      count_d  = '0;
    end else begin
      unique case (state_q)
        StIdle, StWon: begin
          if (i_start) begin
            state_d  = StCountdown;
            winner_d = WinNone;
            loc_d    = LOC_W'(CENTER);
            count_d  = 8'(COUNTDOWN_FRAMES);
          end
        end
        StCountdown: begin
          if (frame_tick) begin
            if (count_q <= 8'd1) begin
              count_d = '0;
              state_d = StPlay;
            end else begin
              count_d = count_q - 8'd1;
            end
          end
        end
        StPlay: begin
          cnt_l_d = cnt_next(cnt_l_q, req_l, frame_tick);
          cnt_r_d = cnt_next(cnt_r_q, req_r, frame_tick);
          if (frame_tick) begin
            loc_d = LOC_W'(next_i);
            if (next_i >= RIGHT_WIN) begin
              winner_d = WinRight;
              state_d  = StWon;
              win_set  = 1'b1;
            end else if (next_i <= LEFT_WIN) begin
              winner_d = WinLeft;
              state_d  = StWon;
              win_set  = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
    irq_d = irq_q;
    if (i_irq_ack) irq_d = 1'b0;
    if (win_set)   irq_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      winner_q <= WinNone;
      loc_q    <= LOC_W'(CENTER);
      count_q  <= '0;
      cnt_l_q  <= '0;
      cnt_r_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      loc_q    <= loc_d;
      count_q  <= count_d;
      cnt_l_q  <= cnt_l_d;
      cnt_r_q  <= cnt_r_d;
      irq_q    <= irq_d;
    end
  end

  assign o_rope_loc = loc_q;
  assign o_state    = state_q;
  assign o_winner   = winner_q;
  assign o_count    = count_q;
  assign o_irq      = irq_q;

endmodule

// File: tb/tb_rope_game_ctrl.sv
// Directed bench for rope_game_ctrl: a behavioural game model queues the
// expected outputs for each frame tick and checks them when the tick lands.
module tb_rope_game_ctrl;

  logic       clk = 1'b0;
  logic       rst, i_vsync, i_pull_l, i_pull_r, i_start, i_abort, i_irq_ack;
  logic [9:0] o_rope_loc;
  logic [1:0] o_state, o_winner;
  logic [7:0] o_count;
  logic       o_irq;

  always #5 clk = ~clk;

  rope_game_ctrl #(.COUNTDOWN_FRAMES(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_vsync   (i_vsync),
    .i_pull_l  (i_pull_l),
    .i_pull_r  (i_pull_r),
    .i_start   (i_start),
    .i_abort   (i_abort),
    .i_irq_ack (i_irq_ack),
    .o_rope_loc(o_rope_loc),
    .o_state   (o_state),
    .o_winner  (o_winner),
    .o_count   (o_count),
    .o_irq     (o_irq)
  );

  typedef struct {int loc; int st; int win; int cnt; int irq;} exp_t;
  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;

  // Behavioural model of the game.
  int m_loc, m_st, m_win, m_cnt, m_irq, m_cl, m_cr;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_e(input string tag, input exp_t e);
    chk({tag, ".loc"},    32'(o_rope_loc), e.loc);
    chk({tag, ".state"},  32'(o_state),    e.st);
    chk({tag, ".winner"}, 32'(o_winner),   e.win);
    chk({tag, ".count"},  32'(o_count),    e.cnt);
    chk({tag, ".irq"},    32'(o_irq),      e.irq);
  endtask

  function automatic exp_t model_now();
    exp_t e;
    e.loc = m_loc; e.st = m_st; e.win = m_win; e.cnt = m_cnt; e.irq = m_irq;
    return e;
  endfunction

  task automatic model_reset();
    m_loc = 320; m_st = 0; m_win = 0; m_cnt = 0; m_irq = 0; m_cl = 0; m_cr = 0;
  endtask

  task automatic pull(input bit l, input bit r);
    i_pull_l = l;
    i_pull_r = r;
    if (m_st == 2) begin
      if (l && m_cl < 15) m_cl++;
      if (r && m_cr < 15) m_cr++;
    end
    step();
    i_pull_l = 1'b0;
    i_pull_r = 1'b0;
    step();
  endtask

  task automatic pulls(input int nl, input int nr);
    for (int i = 0; i < ((nl > nr) ? nl : nr); i++) pull(i < nl, i < nr);
    repeat (4) step();
  endtask

  task automatic start_pulse();
    i_start = 1'b1;
    if (m_st == 0 || m_st == 3) begin
      m_st = 1; m_loc = 320; m_cnt = 3; m_win = 0; m_cl = 0; m_cr = 0;
    end
    step();
    i_start = 1'b0;
  endtask

  // Falling vsync edge, optionally with pulls starting in the same cycle.
  task automatic frame(input string tag, input bit co_l, input bit co_r);
    exp_t e;
    int nxt;
    i_vsync  = 1'b0;
    i_pull_l = co_l;
    i_pull_r = co_r;
    if (m_st == 1) begin
      if (m_cnt <= 1) begin m_cnt = 0; m_st = 2; end
      else m_cnt--;
    end else if (m_st == 2) begin
      nxt = m_loc + (m_cr - m_cl) * 4;
      if (nxt < 0)   nxt = 0;
      if (nxt > 639) nxt = 639;
      m_loc = nxt;
      if (nxt >= 480)      begin m_win = 2; m_st = 3; m_irq = 1; end
      else if (nxt <= 160) begin m_win = 1; m_st = 3; m_irq = 1; end
      m_cl = (m_st == 2) ? int'(co_l) : 0;
      m_cr = (m_st == 2) ? int'(co_r) : 0;
    end
    exp_q.push_back(model_now());
    step();
    i_pull_l = 1'b0;
    i_pull_r = 1'b0;
    repeat (3) step();
    e = exp_q.pop_front();
    chk_e(tag, e);
    i_vsync = 1'b1;
    repeat (4) step();
  endtask

  initial begin
    rst = 1'b1; i_vsync = 1'b1; i_pull_l = 1'b0; i_pull_r = 1'b0;
    i_start = 1'b0; i_abort = 1'b0; i_irq_ack = 1'b0;
    model_reset();
    repeat (3) step();
    rst = 1'b0;
    repeat (4) step();
    chk_e("reset", model_now());

    // Pulls outside PLAY are discarded, including one on the PLAY-entry tick.
    pulls(3, 2);
    start_pulse();
    chk_e("start", model_now());
    pulls(2, 4);
    frame("cd1", 1'b0, 1'b0);
    frame("cd2", 1'b0, 1'b0);
    frame("cd3", 1'b0, 1'b1);
    frame("play_empty", 1'b0, 1'b0);

    // Net 3 right pulls, two of them simultaneous with left pulls.
    pulls(2, 5);
    frame("net_right", 1'b0, 1'b0);
    frame("coincident", 1'b0, 1'b1);
    frame("carried", 1'b0, 1'b0);

    // Saturation and right win.
    pulls(0, 20);
    frame("sat1", 1'b0, 1'b0);
    pulls(0, 15);
    frame("sat2", 1'b0, 1'b0);
    pulls(0, 15);
    frame("right_win", 1'b0, 1'b0);
    pulls(6, 0);
    frame("frozen", 1'b0, 1'b0);
    i_irq_ack = 1'b1; m_irq = 0;
    step();
    i_irq_ack = 1'b0;
    chk_e("ack", model_now());

    // Restart from WON and drive left to exactly 160.
    start_pulse();
    chk_e("restart", model_now());
    frame("cd_b1", 1'b0, 1'b0);
    frame("cd_b2", 1'b0, 1'b0);
    frame("cd_b3", 1'b0, 1'b0);
    pulls(15, 0);
    frame("left1", 1'b0, 1'b0);
    pulls(15, 0);
    frame("left2", 1'b0, 1'b0);
    pulls(10, 0);
    frame("left_win", 1'b0, 1'b0);
    i_irq_ack = 1'b1; m_irq = 0;
    step();
    i_irq_ack = 1'b0;
    step();
    chk_e("ack2", model_now());
    i_irq_ack = 1'b1;
    step();
    i_irq_ack = 1'b0;
    chk_e("ack_idle", model_now());

    // Abort mid-PLAY at 400.
    start_pulse();
    frame("cd_c1", 1'b0, 1'b0);
    frame("cd_c2", 1'b0, 1'b0);
    frame("cd_c3", 1'b0, 1'b0);
    pulls(0, 15);
    frame("to380", 1'b0, 1'b0);
    pulls(0, 5);
    frame("to400", 1'b0, 1'b0);
    i_abort = 1'b1;
    m_st = 0; m_loc = 320; m_win = 0; m_cnt = 0; m_cl = 0; m_cr = 0;
    step();
    i_abort = 1'b0;
    chk_e("abort", model_now());

    // Reset during COUNTDOWN, then start and abort together.
    start_pulse();
    frame("cd_d1", 1'b0, 1'b0);
    rst = 1'b1;
    model_reset();
    step();
    rst = 1'b0;
    chk_e("rst_mid", model_now());
    i_start = 1'b1;
    i_abort = 1'b1;
    step();
    i_start = 1'b0;
    i_abort = 1'b0;
    chk_e("start_abort", model_now());
    frame("idle_tick", 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
